decrypt_ctrl: RTL and testbench

DECRYPT_CTRL -- requirements
Module: decrypt_ctrl

---
 rtl/decrypt_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_decrypt_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_ctrl.sv
// decrypt_ctrl: known-plaintext LFSR tap search and in-place stream decryption.
// Recovers the 7-bit LFSR seed from a space preamble, tries nine tap patterns
// against the preamble, then decrypts DM[64..127] into DM[0..63].
module decrypt_ctrl #(
    parameter int         PRE_CHK = 9,
    parameter logic [7:0] SPACE   = 8'h20
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       req,
    output logic       ack,
    output logic       fail,
    output logic [3:0] ptrn_idx,
    output logic [6:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_CHECK, S_DEC_RD, S_DEC_WR, S_DONE
    } state_t;

    // Candidate tap patterns, searched lowest index first.
    function automatic logic [6:0] tap(input logic [3:0] idx);
        case (idx)
            4'd0:    return 7'h60;
            4'd1:    return 7'h48;
            4'd2:    return 7'h78;
            4'd3:    return 7'h72;
            4'd4:    return 7'h6A;
            4'd5:    return 7'h69;
            4'd6:    return 7'h5C;
            4'd7:    return 7'h7E;
            4'd8:    return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    state_t     state_q, state_d;
    logic       req_q;
    logic       fail_q, fail_d;
    logic [3:0] ptrn_q, ptrn_d;
    logic [6:0] seed_q, seed_d;
    logic [6:0] cur_q, cur_d;
    logic [3:0] k_q, k_d;
    logic [3:0] i_q, i_d;
    logic [6:0] lfsr_q, lfsr_d;
    logic [5:0] j_q, j_d;
    logic [7:0] pt_q, pt_d;

    // The parity bit of every stored byte carries no information here.
    logic       parity_unused;
    assign parity_unused = mem_rdata[7];

    logic [6:0] key_byte;   // stored byte with the known preamble stripped off
    logic [6:0] cand;       // next LFSR value under the pattern being tried
    logic       hit;
    logic       launch;
    logic       req_rise;

    assign key_byte = mem_rdata[6:0] ^ SPACE[6:0];
    assign cand     = lfsr_next(cur_q, tap(k_q));
    assign hit      = (cand == key_byte);
    assign launch   = (state_q == S_IDLE) && req_q && !req;
    assign req_rise = !req_q && req;

    // State and datapath registers; reset clears everything so a run never resumes.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            fail_q  <= 1'b0;
            ptrn_q  <= 4'd0;
            seed_q  <= 7'd0;
            cur_q   <= 7'd0;
            k_q     <= 4'd0;
            i_q     <= 4'd0;
            lfsr_q  <= 7'd0;
            j_q     <= 6'd0;
            pt_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req;
            fail_q  <= fail_d;
            ptrn_q  <= ptrn_d;
            seed_q  <= seed_d;
            cur_q   <= cur_d;
            k_q     <= k_d;
            i_q     <= i_d;
            lfsr_q  <= lfsr_d;
            j_q     <= j_d;
            pt_q    <= pt_d;
        end
    end

    // Next-state and datapath update: seed recovery, pattern search, decrypt loop.
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        ptrn_d  = ptrn_q;
        seed_d  = seed_q;
        cur_d   = cur_q;
        k_d     = k_q;
        i_d     = i_q;
        lfsr_d  = lfsr_q;
        j_d     = j_q;
        pt_d    = pt_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_SEED;
                    fail_d  = 1'b0;
                    ptrn_d  = 4'd0;
                end
            end
            S_SEED: begin
                seed_d = key_byte;
                cur_d  = key_byte;
                k_d    = 4'd0;
                i_d    = 4'd0;
                if (key_byte == 7'd0) begin
                    // An all-zero LFSR never advances; nothing can be decrypted.
                    state_d = S_DONE;
                    fail_d  = 1'b1;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hit) begin
                    if (i_q == 4'(PRE_CHK - 1)) begin
                        ptrn_d  = k_q;
                        lfsr_d  = seed_q;
                        j_d     = 6'd0;
                        state_d = S_DEC_RD;
                    end else begin
                        cur_d = cand;
                        i_d   = i_q + 4'd1;
                    end
                end else if (k_q == 4'd8) begin
                    state_d = S_DONE;
                    fail_d  = 1'b1;
                end else begin
                    k_d   = k_q + 4'd1;
                    cur_d = seed_q;
                    i_d   = 4'd0;
                end
            end
            S_DEC_RD: begin
                pt_d    = {1'b0, mem_rdata[6:0] ^ lfsr_q};
                state_d = S_DEC_WR;
            end
            S_DEC_WR: begin
                lfsr_d  = lfsr_next(lfsr_q, tap(ptrn_q));
                j_d     = j_q + 6'd1;
                state_d = (j_q == 6'd63) ? S_DONE : S_DEC_RD;
            end
            S_DONE: begin
                if (req_rise) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state; writes only ever target DM[0..63].
    always_comb begin
        mem_addr  = 7'd0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        ack       = 1'b0;
        case (state_q)
            S_SEED:   mem_addr = 7'd64;
            S_CHECK:  mem_addr = 7'd65 + {3'b000, i_q};
            S_DEC_RD: mem_addr = {1'b1, j_q};
            S_DEC_WR: begin
                mem_addr  = {1'b0, j_q};
                mem_we    = 1'b1;
                mem_wdata = pt_q;
            end
            S_DONE:   ack = 1'b1;
            default:  ;
        endcase
    end

    assign fail     = fail_q;
    assign ptrn_idx = ptrn_q;

endmodule

// File: tb/tb_decrypt_ctrl.sv
// tb_decrypt_ctrl: scoreboard bench for decrypt_ctrl with a behavioural data memory.
module tb_decrypt_ctrl;

    localparam int         PRE_CHK = 9;
    localparam logic [7:0] SPACE   = 8'h20;

    logic       clk = 1'b0;
    logic       init_n;
    logic       req;
    logic       ack;
    logic       fail;
    logic [3:0] ptrn_idx;
    logic [6:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    decrypt_ctrl #(.PRE_CHK(PRE_CHK), .SPACE(SPACE)) dut (
        .clk      (clk),
        .init_n   (init_n),
        .req      (req),
        .ack      (ack),
        .fail     (fail),
        .ptrn_idx (ptrn_idx),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: bulk image load from the bench, single-byte writes from the DUT.
    logic [7:0]         dm [0:127];
    logic [127:0][7:0]  ld_img;
    logic               ld_go;
    always @(posedge clk) begin
        if (ld_go) begin
            for (int a = 0; a < 128; a++) dm[a] <= ld_img[a];
        end else if (mem_we) begin
            dm[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = dm[mem_addr];

    logic [6:0] taps [0:8] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    typedef struct packed {
        logic             fail;
        logic [3:0]       ptrn;
        logic [31:0]      lat;
        logic [31:0]      launch;
        logic [7:0]       wr;
        logic [63:0][7:0] img;
    } exp_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    // Ten-space preamble, message, space padding to 64 bytes.
    function automatic logic [63:0][7:0] build_pt(input string msg);
        logic [63:0][7:0] pt;
        for (int j = 0; j < 64; j++) begin
            if (j >= 10 && (j - 10) < msg.len()) pt[j] = msg[j - 10];
            else                                 pt[j] = SPACE;
        end
        return pt;
    endfunction

    function automatic logic [63:0][7:0] random_pt();
        logic [63:0][7:0] pt;
        for (int j = 0; j < 64; j++)
            pt[j] = (j < 10) ? SPACE : 8'($urandom_range(32, 126));
        return pt;
    endfunction

    // Stream cipher: ciphertext = plaintext XOR keystream, random parity bit on top.
    function automatic logic [127:0][7:0] encrypt(input logic [63:0][7:0] pt, input logic [6:0] seed,
                                                  input logic [6:0] t, input logic [63:0][7:0] low);
        logic [127:0][7:0] img;
        logic [6:0]        l;
        l = seed;
        for (int j = 0; j < 64; j++) begin
            img[j]      = low[j];
            img[64 + j] = {1'($urandom_range(0, 1)), pt[j][6:0] ^ l};
            l           = step(l, t);
        end
        return img;
    endfunction

    // Expected outcome of one run over a memory image.
    function automatic exp_t model(input logic [127:0][7:0] img);
        exp_t       e;
        logic [6:0] seed;
        logic [6:0] s;
        logic [6:0] l;
        int         checks;
        int         found;
        bit         ok;
        e      = '0;
        e.img  = img[63:0];
        seed   = img[64][6:0] ^ SPACE[6:0];
        checks = 0;
        found  = -1;
        if (seed == 7'd0) begin
            e.fail = 1'b1;
            e.lat  = 2;
            return e;
        end
        for (int k = 0; k < 9 && found < 0; k++) begin
            s  = seed;
            ok = 1'b1;
            for (int i = 0; i < PRE_CHK && ok; i++) begin
                s = step(s, taps[k]);
                checks++;
                if (s != (img[65 + i][6:0] ^ SPACE[6:0])) ok = 1'b0;
            end
            if (ok) found = k;
        end
        if (found < 0) begin
            e.fail = 1'b1;
            e.lat  = 32'(checks + 2);
        end else begin
            e.ptrn = 4'(found);
            l      = seed;
            for (int j = 0; j < 64; j++) begin
                e.img[j] = {1'b0, img[64 + j][6:0] ^ l};
                l        = step(l, taps[found]);
            end
            e.lat = 32'(checks + 130);
            e.wr  = 8'd64;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    exp_t mon_e;
    initial begin
        int unsigned wr_cnt   = 0;
        int unsigned bad_addr = 0;
        int unsigned nbad     = 0;
        logic        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!init_n) begin
                wr_cnt   = 0;
                bad_addr = 0;
                ack_prev = 1'b0;
            end else begin
                if (mem_we) begin
                    wr_cnt++;
                    if (mem_addr[6]) bad_addr++;
                end
                if (ack && !ack_prev) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_ack: got ack=1, expected no pending run (t=%0t)", $time);
                    end else begin
                        mon_e = sb.pop_front();
                        check("fail", fail, mon_e.fail);
                        if (!mon_e.fail) check("ptrn_idx", ptrn_idx, mon_e.ptrn);
                        check("latency", cyc - mon_e.launch, mon_e.lat);
                        check("write_count", wr_cnt, mon_e.wr);
                        check("write_addr_hi", bad_addr, 0);
                        nbad = 0;
                        for (int a = 0; a < 64; a++) if (dm[a] !== mon_e.img[a]) nbad++;
                        check("mem_bytes_bad", nbad, 0);
                    end
                    wr_cnt   = 0;
                    bad_addr = 0;
                end
                ack_prev = ack;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input logic [127:0][7:0] img);
        @(negedge clk);
        ld_img = img;
        ld_go  = 1'b1;
        @(negedge clk);
        ld_go  = 1'b0;
    endtask

    // Expects req=1 held for at least one edge beforehand.
    task automatic launch(input logic [127:0][7:0] img);
        exp_t e;
        e = model(img);
        @(negedge clk);
        e.launch = cyc;
        sb.push_back(e);
        req = 1'b0;
    endtask

    task automatic wait_ack();
        bit seen = 1'b0;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge clk);
            seen = ack;
        end
        check("ack_seen", seen, 1);
    endtask

    task automatic release_done();
        req = 1'b1;
        @(negedge clk);
        check("ack_clear", ack, 0);
        @(negedge clk);
    endtask

    logic [127:0][7:0] img;
    logic [63:0][7:0]  pt_msg;
    exp_t              probe;

    initial begin
        int unsigned nb;
        bit          found;
        init_n = 1'b0;
        req    = 1'b1;
        ld_go  = 1'b0;
        ld_img = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_fail", fail, 0);
        check("rst_ptrn", ptrn_idx, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        init_n = 1'b1;
        repeat (3) @(negedge clk);

        pt_msg = build_pt("Knowledge comes, but wisdom lingers");

        // Pattern 0, seed 0x01.
        img = encrypt(pt_msg, 7'h01, taps[0], {64{8'hEE}});
        load(img);
        launch(img);
        wait_ack();
        release_done();

        // Pattern 8, seed 0x5A; a req rise mid-run is ignored, then ack held.
        img = encrypt(pt_msg, 7'h5A, taps[8], {64{8'h55}});
        load(img);
        launch(img);
        repeat (40) @(negedge clk);
        req = 1'b1;
        wait_ack();
        repeat (5) @(negedge clk);
        check("ack_hold", ack, 1);
        req = 1'b0;
        repeat (2) @(negedge clk);
        check("ack_hold_req_low", ack, 1);
        req = 1'b1;
        @(negedge clk);
        check("ack_clear_on_rise", ack, 0);
        @(negedge clk);
        launch(img);
        wait_ack();
        release_done();

        // Zero seed with the parity bit set.
        img = encrypt(pt_msg, 7'h01, taps[0], {64{8'hC3}});
        img[64] = 8'hA0;
        load(img);
        launch(img);
        wait_ack();
        release_done();

        // Random content that no pattern explains.
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            for (int a = 0; a < 128; a++) img[a] = 8'($urandom);
            probe = model(img);
            found = probe.fail;
        end
        load(img);
        launch(img);
        wait_ack();
        release_done();

        // Random taps, seeds and messages.
        for (int r = 0; r < 4; r++) begin
            img = encrypt(random_pt(), 7'($urandom_range(1, 127)), taps[$urandom_range(0, 8)],
                          {64{8'h99}});
            load(img);
            launch(img);
            wait_ack();
            release_done();
        end

        // Reset while the write of byte 20 is pending.
        img = encrypt(pt_msg, 7'h33, taps[0], {64{8'hEE}});
        load(img);
        @(negedge clk);
        req   = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 600 && !found; n++) begin
            @(negedge clk);
            found = mem_we && (mem_addr == 7'd20);
        end
        check("abort_reached_j20", found, 1);
        init_n = 1'b0;
        #1;
        check("abort_ack", ack, 0);
        check("abort_we", mem_we, 0);
        @(negedge clk);
        @(negedge clk);
        nb = 0;
        for (int a = 0; a < 64; a++) begin
            if (a < 20) begin
                if (dm[a] !== pt_msg[a]) nb++;
            end else begin
                if (dm[a] !== 8'hEE) nb++;
            end
        end
        check("abort_mem_bytes_bad", nb, 0);
        init_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_launch_after_reset_addr", mem_addr, 0);
        check("no_launch_after_reset_ack", ack, 0);
        req = 1'b1;
        repeat (2) @(negedge clk);
        launch(img);
        wait_ack();
        release_done();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
